// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Request/acknowledge data-memory bus between the MEM-stage access controller
// (master) and the external data memory / IO fabric (slave).
//
// Signals
//   bus_req    master->slave  request, held until bus_ack
//   bus_we     master->slave  write strobe
//   bus_addr   master->slave  word-aligned byte address (bits [1:0] = 0)
//   bus_be     master->slave  byte enables
//   bus_wdata  master->slave  lane-replicated store data
//   bus_err    master->slave  one-cycle abort pulse on timeout
//   bus_ack    slave->master  single-cycle completion
//   bus_rdata  slave->master  read word, valid with bus_ack
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_be;
   logic [31:0]       bus_wdata;
   logic              bus_err;
   logic              bus_ack;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Turns the MEM-stage load/store controls into a request/acknowledge bus
// transaction, freezes the pipeline until it completes, builds byte enables
// and replicated store data, and returns sign/zero-extended load data.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   memread       MEM-stage instruction is a load
//   memwrite      MEM-stage instruction is a store (wins if both are set)
//   funct3        000 B, 001 H, 010 W, 100 BU, 101 HU; others unsupported
//   addr          byte address from the ALU
//   wdata         store data (rs2)
//   rdata         extended load data, valid in DONE
//   stall         freeze IF/ID/EX/MEM registers
//   misalign_err  one-cycle pulse for a misaligned or unsupported access
//   bus           dmem_access_ctrl_if.master
//
// Optional feature
//   DMEM_TIMEOUT_EN : abort a BUSY transaction after TIMEOUT_CYCLES cycles
//                     without bus_ack (bus_err pulse, rdata = 0). When not
//                     defined, BUSY waits forever and bus_err is tied 0.
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              misalign_err,
   dmem_access_ctrl_if.master bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t            r_state;
   state_t            w_next_state;
   logic              r_bus_req;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [3:0]        r_bus_be;
   logic [31:0]       r_bus_wdata;
   logic [31:0]       r_rdata;
   logic              r_misalign_err;
   logic [1:0]        r_lane;      // addr[1:0] of the access in flight
   logic [2:0]        r_funct3;    // size/sign of the access in flight

   logic              w_req_valid;
   logic              w_aligned;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_data;
   logic              w_timeout;

   assign w_req_valid = memread | memwrite;

   // Alignment and size decode of the incoming request.
   // NOTE: every signal driven in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_aligned = 1'b0;
      w_be      = 4'b1111;
      w_wdata   = wdata;
      case (funct3)
         3'b000, 3'b100: begin
            w_aligned = 1'b1;
            w_be      = 4'b0001 << addr[1:0];
            w_wdata   = {4{wdata[7:0]}};
         end
         3'b001, 3'b101: begin
            w_aligned = ~addr[0];
            w_be      = 4'b0011 << addr[1:0];
            w_wdata   = {2{wdata[15:0]}};
         end
         3'b010: w_aligned = (addr[1:0] == 2'b00);
         default: w_aligned = 1'b0;
      endcase
   end

   // Lane extraction uses the registered address/size, since the pipeline
   // inputs are only guaranteed stable, not re-decoded, while BUSY.
   always_comb begin
      w_byte      = 8'(bus.bus_rdata >> {r_lane, 3'b000});
      w_half      = r_lane[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      w_load_data = bus.bus_rdata;
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_data = {24'h0, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_data = {16'h0, w_half};
         default: w_load_data = bus.bus_rdata;
      endcase
   end

   // Next state and stall. Stall is combinational in IDLE so the request
   // cycle itself already freezes the pipeline.
   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            stall = w_req_valid & w_aligned;
            if (w_req_valid && w_aligned) w_next_state = ST_BUSY;
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (bus.bus_ack || w_timeout) w_next_state = ST_DONE;
         end
         ST_DONE: w_next_state = ST_IDLE;  // same frozen instruction, ignore it
         default: w_next_state = ST_IDLE;
      endcase
      if (reset) stall = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; reset is synchronous and sampled on the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_bus_req      <= 1'b0;
         r_bus_we       <= 1'b0;
         r_bus_addr     <= '0;
         r_bus_be       <= 4'b0000;
         r_bus_wdata    <= 32'h0;
         r_rdata        <= 32'h0;
         r_misalign_err <= 1'b0;
         r_lane         <= 2'b00;
         r_funct3       <= 3'b000;
      end else begin
         r_state        <= w_next_state;
         r_misalign_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req_valid && !w_aligned) begin
                  r_misalign_err <= 1'b1;
                  r_rdata        <= 32'h0;
               end else if (w_req_valid) begin
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= memwrite;
                  r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  r_bus_be    <= w_be;
                  r_bus_wdata <= w_wdata;
                  r_lane      <= addr[1:0];
                  r_funct3    <= funct3;
               end
            end
            ST_BUSY: begin
               if (bus.bus_ack) begin
                  r_bus_req <= 1'b0;
                  r_bus_we  <= 1'b0;
                  if (!r_bus_we) r_rdata <= w_load_data;  // stores leave rdata alone
               end else if (w_timeout) begin
                  r_bus_req <= 1'b0;
                  r_bus_we  <= 1'b0;
                  r_rdata   <= 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] r_to_cnt;
   logic             r_bus_err;

   // Counter sits at zero outside BUSY, so it is clear on BUSY entry and
   // holds the number of BUSY cycles already completed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_to_cnt  <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
         if (r_state == ST_BUSY) r_to_cnt <= r_to_cnt + CNT_W'(1);
         else                    r_to_cnt <= '0;
      end
   end

   assign w_timeout   = (r_state == ST_BUSY) && !bus.bus_ack &&
                        (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign bus.bus_err = r_bus_err;
`else
   assign w_timeout   = 1'b0;
   assign bus.bus_err = 1'b0;
`endif

   assign bus.bus_req   = r_bus_req;
   assign bus.bus_we    = r_bus_we;
   assign bus.bus_addr  = r_bus_addr;
   assign bus.bus_be    = r_bus_be;
   assign bus.bus_wdata = r_bus_wdata;
   assign rdata         = r_rdata;
   assign misalign_err  = r_misalign_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Self-checking bench for dmem_access_ctrl: reset state, a table of directed
// accesses, hand-written multi-cycle sequences (reset during BUSY, no-ack
// hang or timeout) and randomized accesses checked against a reference model.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

   localparam int ADDR_W = 32;
   localparam int TO_CYC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread, memwrite;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, rdata;
   logic        stall, misalign_err;

   dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk          (clk),
      .reset        (reset),
      .memread      (memread),
      .memwrite     (memwrite),
      .funct3       (funct3),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata),
      .stall        (stall),
      .misalign_err (misalign_err),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rdat;
      int          ack_dly;    // BUSY cycle (1-based) carrying bus_ack
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      int          exp_stall;
      logic        exp_mis;
   } vec_t;

   typedef struct {
      int          nstall;
      int          nbusy;
      logic        we;
      logic [31:0] baddr;
      logic [3:0]  be;
      logic [31:0] bwdata;
      logic        stable;
      logic        timed_out;
   } obs_t;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] model_rdata;
   vec_t        tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: derived from the size/alignment/lane rules with plain
   // arithmetic on byte counts and offsets.
   function automatic vec_t model(input string name, input logic rd, input logic wr,
                                  input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rdat,
                                  input int ack_dly, input logic [31:0] prev);
      vec_t   v;
      int     size;
      int     off;
      bit     ok;
      longint val;
      v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
      v.rdat = rdat; v.ack_dly = ack_dly;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      off = int'(a % 4);
      ok  = (size != 0) && ((a % size) == 0);
      v.exp_mis   = !ok;
      v.exp_stall = ok ? ack_dly + 1 : 0;
      v.exp_we    = wr;
      v.exp_addr  = a - 32'(off);
      v.exp_be    = 4'h0;
      v.exp_wdata = 32'h0;
      v.exp_rdata = 32'h0;
      if (ok) begin
         v.exp_be = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << off);
         for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
         if (wr) begin
            v.exp_rdata = prev;
         end else begin
            val = (longint'(rdat) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
            if (!f3[2] && size < 4 && val >= longint'(64'd1 << (8 * size - 1)))
               val = val - longint'(64'd1 << (8 * size));
            v.exp_rdata = val[31:0];
         end
      end
      return v;
   endfunction

   // Drives one access and plays the memory: bus_ack in BUSY cycle ack_dly.
   // Returns in the first cycle with stall low (DONE, or IDLE if rejected).
   task automatic run_access(input vec_t v, output obs_t o);
      o = '{nstall: 0, nbusy: 0, we: 1'b0, baddr: 32'h0, be: 4'h0, bwdata: 32'h0,
            stable: 1'b1, timed_out: 1'b1};
      @(negedge clk);
      memread = v.rd; memwrite = v.wr; funct3 = v.f3; addr = v.a; wdata = v.wd;
      bus.bus_ack = 1'b0;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (stall) o.nstall++;
         if (bus.bus_req) begin
            o.nbusy++;
            if (o.nbusy == 1) begin
               o.we = bus.bus_we; o.baddr = bus.bus_addr; o.be = bus.bus_be;
               o.bwdata = bus.bus_wdata;
            end else if ({bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata} !==
                         {o.we, o.baddr, o.be, o.bwdata}) begin
               o.stable = 1'b0;
            end
            bus.bus_ack   = (o.nbusy == v.ack_dly);
            bus.bus_rdata = bus.bus_ack ? v.rdat : ~v.rdat;
         end else begin
            bus.bus_ack = 1'b0;
         end
         if (!stall) begin
            o.timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      obs_t o;
      run_access(v, o);
      check({v.name, ".bound"},  32'(o.timed_out), 32'h0);
      check({v.name, ".stall"},  32'(o.nstall), 32'(v.exp_stall));
      if (v.exp_mis) begin
         check({v.name, ".no_bus"}, 32'(o.nbusy), 32'h0);
         @(negedge clk);
         memread = 1'b0; memwrite = 1'b0;
         #1;
         check({v.name, ".mis_pulse"}, 32'(misalign_err), 32'h1);
         check({v.name, ".rdata"},     rdata, 32'h0);
         check({v.name, ".req_low"},   32'(bus.bus_req), 32'h0);
         @(negedge clk);
         #1;
         check({v.name, ".mis_end"},   32'(misalign_err), 32'h0);
      end else begin
         check({v.name, ".rdata"},  rdata, v.exp_rdata);
         check({v.name, ".we"},     32'(o.we), 32'(v.exp_we));
         check({v.name, ".addr"},   o.baddr, v.exp_addr);
         check({v.name, ".be"},     32'(o.be), 32'(v.exp_be));
         if (v.wr) check({v.name, ".wdata"}, o.bwdata, v.exp_wdata);
         check({v.name, ".stable"}, 32'(o.stable), 32'h1);
         @(negedge clk);
         memread = 1'b0; memwrite = 1'b0;
         #1;
         check({v.name, ".no_reissue"}, 32'(bus.bus_req), 32'h0);
      end
      model_rdata = v.exp_rdata;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      int   sel;
      logic rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic hold_ok;
      int   nst, nb;

      //                name        rd    wr    f3      a        wd            rdat          ack  we    addr     be     wdata         rdata         st  mis
      tbl[0]  = '{"LW_100",    1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 4, 1'b0};
      tbl[1]  = '{"LB_103",    1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80123456, 1, 1'b0, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80, 2, 1'b0};
      tbl[2]  = '{"LBU_103",   1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80123456, 1, 1'b0, 32'h100, 4'h8, 32'h0,        32'h00000080, 2, 1'b0};
      tbl[3]  = '{"SH_202",    1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        1, 1'b1, 32'h200, 4'hC, 32'hABCDABCD, 32'h00000080, 2, 1'b0};
      tbl[4]  = '{"LW_101",    1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0,        0, 1'b1};
      tbl[5]  = '{"LH_102",    1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 2, 1'b0, 32'h100, 4'hC, 32'h0,        32'hFFFF8001, 3, 1'b0};
      tbl[6]  = '{"LHU_102",   1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 1, 1'b0, 32'h100, 4'hC, 32'h0,        32'h00008001, 2, 1'b0};
      tbl[7]  = '{"SB_001",    1'b0, 1'b1, 3'b000, 32'h001, 32'h12345678, 32'h0,        1, 1'b1, 32'h0,   4'h2, 32'h78787878, 32'h00008001, 2, 1'b0};
      tbl[8]  = '{"LH_003",    1'b1, 1'b0, 3'b001, 32'h003, 32'h0,        32'h0,        1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0,        0, 1'b1};
      tbl[9]  = '{"F3_011",    1'b1, 1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        1, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0,        0, 1'b1};
      tbl[10] = '{"SW_RW_010", 1'b1, 1'b1, 3'b010, 32'h010, 32'hCAFEF00D, 32'h0,        2, 1'b1, 32'h010, 4'hF, 32'hCAFEF00D, 32'h0,        3, 1'b0};
      tbl[11] = '{"LB_041",    1'b1, 1'b0, 3'b000, 32'h041, 32'h0,        32'h00007F00, 1, 1'b0, 32'h040, 4'h2, 32'h0,        32'h0000007F, 2, 1'b0};
      tbl[12] = '{"LBU_002",   1'b1, 1'b0, 3'b100, 32'h002, 32'h0,        32'h00FF0000, 1, 1'b0, 32'h000, 4'h4, 32'h0,        32'h000000FF, 2, 1'b0};

      // Reset with a load request present: stall must stay low.
      reset = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010;
      addr = 32'h0; wdata = 32'h0; bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("rst.stall",     32'(stall), 32'h0);
      check("rst.bus_req",   32'(bus.bus_req), 32'h0);
      check("rst.bus_we",    32'(bus.bus_we), 32'h0);
      check("rst.bus_addr",  bus.bus_addr, 32'h0);
      check("rst.bus_be",    32'(bus.bus_be), 32'h0);
      check("rst.bus_wdata", bus.bus_wdata, 32'h0);
      check("rst.rdata",     rdata, 32'h0);
      check("rst.misalign",  32'(misalign_err), 32'h0);
      check("rst.bus_err",   32'(bus.bus_err), 32'h0);
      @(negedge clk);
      reset = 1'b0; memread = 1'b0;
      model_rdata = 32'h0;

      foreach (tbl[i]) apply_vec(tbl[i]);

      // Reset during BUSY, then a late ack that must be ignored.
      @(negedge clk);
      memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h300; bus.bus_ack = 1'b0;
      @(negedge clk);
      #1;
      check("rstbusy.req_up", 32'(bus.bus_req), 32'h1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rstbusy.stall_forced", 32'(stall), 32'h0);
      @(negedge clk);
      #1;
      check("rstbusy.req_dropped", 32'(bus.bus_req), 32'h0);
      reset = 1'b0; memread = 1'b0;
      bus.bus_ack = 1'b1; bus.bus_rdata = 32'hBAD0BAD0;
      #1;
      check("rstbusy.idle_stall", 32'(stall), 32'h0);
      @(negedge clk);
      bus.bus_ack = 1'b0;
      #1;
      check("rstbusy.ack_ignored_req", 32'(bus.bus_req), 32'h0);
      check("rstbusy.ack_ignored_rd",  rdata, 32'h0);
      model_rdata = 32'h0;
      apply_vec(model("LW_after_rst", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h13579BDF, 1, model_rdata));

`ifdef DMEM_TIMEOUT_EN
      // No ack: abort after TO_CYC BUSY cycles.
      @(negedge clk);
      memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h84; bus.bus_ack = 1'b0;
      nst = 0; nb = 0; hold_ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (stall) nst++;
         if (bus.bus_req) nb++;
         if (!stall) begin
            hold_ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("to.released",   32'(hold_ok), 32'h1);
      check("to.busy_cyc",   32'(nb), 32'(TO_CYC));
      check("to.stall_cyc",  32'(nst), 32'(TO_CYC + 1));
      check("to.bus_err",    32'(bus.bus_err), 32'h1);
      check("to.rdata",      rdata, 32'h0);
      check("to.req_low",    32'(bus.bus_req), 32'h0);
      @(negedge clk);
      memread = 1'b0;
      #1;
      check("to.err_end",    32'(bus.bus_err), 32'h0);
      model_rdata = 32'h0;
`else
      // No ack: stall must hold indefinitely; finish with a late ack.
      @(negedge clk);
      memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h80; bus.bus_ack = 1'b0;
      hold_ok = 1'b1;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (!stall) hold_ok = 1'b0;
         @(negedge clk);
      end
      check("hang.stall_held", 32'(hold_ok), 32'h1);
      #1;
      check("hang.req_held",   32'(bus.bus_req), 32'h1);
      check("hang.no_err",     32'(bus.bus_err), 32'h0);
      bus.bus_ack = 1'b1; bus.bus_rdata = 32'h12345678;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      #1;
      check("hang.done_stall", 32'(stall), 32'h0);
      check("hang.rdata",      rdata, 32'h12345678);
      @(negedge clk);
      memread = 1'b0;
      model_rdata = 32'h12345678;
      nst = 0; nb = 0;
`endif

      // Randomized accesses against the reference model.
      for (int n = 0; n < 60; n++) begin
         f3 = 3'($urandom_range(0, 7));
         if ((f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && $urandom_range(0, 3) != 0) f3 = 3'b010;
         a = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            a[0] = 1'b0;
            if (f3 == 3'b010) a[1] = 1'b0;
         end
         sel = $urandom_range(0, 4);
         rd  = (sel <= 1) || (sel == 4);
         wr  = (sel >= 2);
         v = model($sformatf("rnd%0d", n), rd, wr, f3, a, $urandom, $urandom,
                   $urandom_range(1, 4), model_rdata);
         apply_vec(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
